// File: rtl/uart_hex_tx.sv
// uart_hex_tx: buffers register bytes in a small FIFO and prints each one on
// the UART line as two uppercase hex digits followed by CR LF (8N1 framing).
// Every bit lasts CLKS_PER_BIT clocks. Consecutive bytes are separated by a
// single idle-high LOAD cycle.

module uart_hex_tx #(
  parameter int CLKS_PER_BIT = 100,
  parameter int FIFO_AW      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_vld,
  input  logic [7:0] in_data,
  output logic       in_rdy,
  output logic       tx,
  output logic       busy,
  output logic       ovf
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // ASCII for one nibble, uppercase letters above 9
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) c = 8'h30 + {4'h0, n};
    else           c = 8'h37 + {4'h0, n};
    return c;
  endfunction

  // Character idx of the four printed for byte b
  function automatic logic [7:0] char_sel(input logic [7:0] b, input logic [1:0] idx);
    logic [7:0] c;
    case (idx)
      2'd0:    c = hex_char(b[7:4]);
      2'd1:    c = hex_char(b[3:0]);
      2'd2:    c = 8'h0D;
      default: c = 8'h0A;
    endcase
    return c;
  endfunction

  // FIFO storage and bookkeeping
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // Serializer state
  state_t         state;
  state_t         state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]     bit_idx;
  logic [2:0]     bit_d;
  logic [1:0]     chr_idx;
  logic [1:0]     chr_d;
  logic [7:0]     byte_q;
  logic [7:0]     ch_d;
  logic           tx_q;
  logic           tx_d;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign in_rdy = !full;
  assign push   = in_vld && !full;
  assign busy   = (state != S_IDLE) || !empty;
  assign tx     = tx_q;

  // FIFO payload write; storage needs no reset, the count defines validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag: a byte offered while full is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ovf <= 1'b0;
    else if (in_vld && full)   ovf <= 1'b1;
  end

  // Byte being printed, captured from the FIFO head on every pop
  always_ff @(posedge clk) begin
    if (pop) byte_q <= mem[rd_ptr];
  end

  // State register with bit timer, bit index, char index and line driver
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      chr_idx <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      chr_idx <= chr_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic: bit timer reloads at the start of every bit
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    chr_d   = chr_idx;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_LOAD;
          pop     = 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_START;
        cnt_d   = BIT_LAST;
        chr_d   = 2'd0;
      end
      S_START: begin
        if (cnt == '0) begin
          state_d = S_DATA;
          cnt_d   = BIT_LAST;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          cnt_d = BIT_LAST;
          if (bit_idx == 3'd7) state_d = S_STOP;
          else                 bit_d   = bit_idx + 3'd1;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt == '0) begin
          if (chr_idx != 2'd3) begin
            state_d = S_START;
            cnt_d   = BIT_LAST;
            chr_d   = chr_idx + 2'd1;
          end else if (!empty) begin
            state_d = S_LOAD;
            pop     = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: line level for the upcoming state, registered into tx_q
  always_comb begin
    ch_d = char_sel(byte_q, chr_d);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = ch_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_hex_tx.sv
// tb_uart_hex_tx: directed and randomized pushes into uart_hex_tx, with a
// line decoder that reconstructs each 8N1 frame and a reference model that
// turns pushed bytes into the expected character stream and frame timing.

module tb_uart_hex_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       in_vld  = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_rdy;
  logic       tx;
  logic       busy;
  logic       ovf;

  uart_hex_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_AW     (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vld (in_vld),
    .in_data(in_data),
    .in_rdy (in_rdy),
    .tx     (tx),
    .busy   (busy),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ch;
    bit         ok;
    int         start;
  } frame_t;

  int         vecs = 0;
  int         errs = 0;
  frame_t     frames[$];
  logic [7:0] exp_q[$];
  logic [7:0] stim_q[$];
  logic       rdy_obs[$];
  string      hx = "0123456789ABCDEF";

  // line decoder state
  int   cyc      = 0;
  bit   in_frame = 1'b0;
  int   pos      = 0;
  int   fstart   = 0;
  logic samp [FRAME];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vecs++;
    assert (obs === want) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // reference model: printable form of one byte
  function automatic void add_byte(input logic [7:0] b);
    exp_q.push_back(8'(hx.getc(int'(b[7:4]))));
    exp_q.push_back(8'(hx.getc(int'(b[3:0]))));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // decoder: each frame is FRAME samples starting at the first low sample
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        if (tx === 1'b0) begin
          in_frame = 1'b1;
          pos      = 0;
          samp[0]  = tx;
          fstart   = cyc;
        end
      end else begin
        pos++;
        samp[pos] = tx;
        if (pos == FRAME - 1) begin
          frame_t f;
          logic   lvl;
          f.ok    = 1'b1;
          f.ch    = 8'h00;
          f.start = fstart;
          for (int j = 0; j < 10; j++) begin
            if (j == 0)      lvl = 1'b0;
            else if (j == 9) lvl = 1'b1;
            else begin
              lvl         = samp[j * CPB + CPB / 2];
              f.ch[j - 1] = lvl;
            end
            for (int s = 0; s < CPB; s++)
              if (samp[j * CPB + s] !== lvl) f.ok = 1'b0;
          end
          frames.push_back(f);
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    in_vld  = 1'b1;
    in_data = b;
    @(posedge clk);
    #1;
    in_vld  = 1'b0;
    in_data = 8'($urandom);
  endtask

  // pushes stim_q on consecutive edges, recording in_rdy seen before each edge
  task automatic push_seq();
    rdy_obs.delete();
    for (int i = 0; i < stim_q.size(); i++) begin
      @(negedge clk);
      in_vld  = 1'b1;
      in_data = stim_q[i];
      rdy_obs.push_back(in_rdy);
    end
    @(negedge clk);
    in_vld  = 1'b0;
    in_data = 8'($urandom);
  endtask

  task automatic idle_check(input string tag, input int n);
    int lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk(tag, 32'(lows), 32'd0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || in_frame) && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " drained"}, 32'(t < budget), 32'd1);
  endtask

  // compares decoded frames with the model: chars, clean bit widths, and
  // back-to-back timing (FRAME per char plus one LOAD cycle per byte boundary)
  task automatic check_burst(input string tag);
    chk({tag, " count"}, 32'(frames.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < frames.size(); i++) begin
      chk($sformatf("%s ch%0d", tag, i), 32'(frames[i].ch), 32'(exp_q[i]));
      chk($sformatf("%s width%0d", tag, i), 32'(frames[i].ok), 32'd1);
      chk($sformatf("%s start%0d", tag, i), 32'(frames[i].start),
          32'(frames[0].start + i * FRAME + i / 4));
    end
  endtask

  task automatic clear_model();
    frames.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    logic [7:0] b;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst tx", 32'(tx), 32'd1);
    chk("rst in_rdy", 32'(in_rdy), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    idle_check("post-reset idle", 50);
    chk("post-reset busy", 32'(busy), 32'd0);

    // single byte 3C: latency and busy duration
    clear_model();
    push(8'h3C);
    @(negedge clk);
    chk("t2 tx after push", 32'(tx), 32'd1);
    chk("t2 busy after push", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t2 tx in load", 32'(tx), 32'd1);
    @(negedge clk);
    chk("t2 tx start at N+2", 32'(tx), 32'd0);
    repeat (159) @(negedge clk);
    chk("t2 busy last cycle", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t2 busy falls", 32'(busy), 32'd0);
    chk("t2 tx idle", 32'(tx), 32'd1);
    add_byte(8'h3C);
    wait_idle("t2", 400);
    check_burst("t2");
    idle_check("t2 idle", 20);

    // 00 then FF back-to-back
    clear_model();
    stim_q = '{8'h00, 8'hFF};
    push_seq();
    add_byte(8'h00);
    add_byte(8'hFF);
    wait_idle("t3", 800);
    check_burst("t3");
    idle_check("t3 idle", 20);

    // randomized bursts with short random gaps (never fills the FIFO)
    for (int r = 0; r < 3; r++) begin
      clear_model();
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        add_byte(b);
        push(b);
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      wait_idle($sformatf("rnd%0d", r), 2000);
      check_burst($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d ovf", r), 32'(ovf), 32'd0);
      idle_check($sformatf("rnd%0d idle", r), 10);
    end

    // six pushes on consecutive edges: five fit, sixth is dropped
    clear_model();
    stim_q.delete();
    for (int k = 0; k < 6; k++) stim_q.push_back(8'($urandom));
    push_seq();
    for (int k = 0; k < 6; k++)
      chk($sformatf("t4 in_rdy%0d", k), 32'(rdy_obs[k]), 32'(k < 5));
    chk("t4 ovf set", 32'(ovf), 32'd1);
    for (int k = 0; k < 5; k++) add_byte(stim_q[k]);
    wait_idle("t4", 4000);
    check_burst("t4");
    chk("t4 ovf sticky", 32'(ovf), 32'd1);
    idle_check("t4 idle", 20);

    // reset during DATA of the second char of A5
    clear_model();
    push(8'hA5);
    repeat (52) @(negedge clk);
    chk("t5 pre-reset data bit", 32'(tx), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5 reset tx", 32'(tx), 32'd1);
    chk("t5 reset busy", 32'(busy), 32'd0);
    chk("t5 reset in_rdy", 32'(in_rdy), 32'd1);
    chk("t5 reset ovf", 32'(ovf), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    idle_check("t5 idle after release", 30);
    chk("t5 busy after release", 32'(busy), 32'd0);
    push(8'h07);
    add_byte(8'h07);
    wait_idle("t5", 400);
    idle_check("t5 final idle", 60);
    check_burst("t5");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  // global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
